// File: rtl/uart_msg_sched_if.sv
// Request/operand inputs and UART byte handshake for uart_msg_sched.
interface uart_msg_sched_if;
    logic [2:0]  req;
    logic [23:0] arg;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [1:0]  active_src;
    logic        done;
    logic [2:0]  drop;

    modport master (
        output req, arg, tx_ready,
        input  tx_data, tx_valid, busy, active_src, done, drop
    );

    modport slave (
        input  req, arg, tx_ready,
        output tx_data, tx_valid, busy, active_src, done, drop
    );
endinterface

// File: rtl/uart_msg_sched.sv
// Round-robin scheduler for IDENT/PICK/DUMP messages feeding a byte UART,
// with a programmable idle gap after each message.
//
// state | meaning
// IDLE  | no message in flight; grants the round-robin winner if any pending
// SEND  | presenting message bytes on tx_data/tx_valid
// GAP   | inter-message idle time, down-counter to zero
module uart_msg_sched #(
    parameter int GAP_CYCLES = 434
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_msg_sched_if.slave bus
);
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    pending_q, pending_d;
    logic [23:0]   arg_lat_q, arg_lat_d;
    logic [7:0]    opnd_q, opnd_d;
    logic [1:0]    src_q, src_d;
    logic [1:0]    rr_q, rr_d;
    logic [3:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          done_q, done_d;
    logic [2:0]    drop_q, drop_d;

    logic [1:0]    cand, win;
    logic          found;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [3:0] last_idx(input logic [1:0] src);
        return (src == 2'd0) ? 4'd5 : 4'd8;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [1:0] src, input logic [3:0] idx,
                                            input logic [7:0] a);
        logic       ident;
        logic       pick;
        logic [7:0] b;
        ident = (src == 2'd0);
        pick  = (src == 2'd1);
        case (idx)
            4'd0:    b = ident ? 8'h49 : (pick ? 8'h50 : 8'h44);
            4'd1:    b = ident ? 8'h2D : (pick ? 8'h49 : 8'h55);
            4'd2:    b = ident ? a     : (pick ? 8'h43 : 8'h4D);
            4'd3:    b = ident ? 8'h2D : (pick ? 8'h4B : 8'h50);
            4'd4:    b = ident ? 8'h23 : 8'h2D;
            4'd5:    b = ident ? 8'h00 : a;
            4'd6:    b = 8'h2D;
            4'd7:    b = 8'h23;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // First pending source in the order rr, rr+1, rr+2.
    always_comb begin
        cand  = rr_q;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && pending_q[cand]) begin
                win   = cand;
                found = 1'b1;
            end
            cand = inc3(cand);
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        arg_lat_d  = arg_lat_q;
        opnd_d     = opnd_q;
        src_d      = src_q;
        rr_d       = rr_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        drop_d     = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d        = ST_SEND;
                    pending_d[win] = 1'b0;
                    src_d          = win;
                    rr_d           = inc3(win);
                    opnd_d         = arg_lat_q[{win, 3'b000} +: 8];
                    idx_d          = 4'd0;
                    tx_valid_d     = 1'b1;
                    tx_data_d      = msg_byte(win, 4'd0, arg_lat_q[{win, 3'b000} +: 8]);
                end
            end
            ST_SEND: begin
                if (tx_valid_q && bus.tx_ready) begin
                    if (idx_q == last_idx(src_q)) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = msg_byte(src_q, idx_q + 4'd1, opnd_q);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // A request landing on its own grant edge sees the cleared flag and is accepted.
        for (int i = 0; i < 3; i++) begin
            if (bus.req[i]) begin
                if (pending_d[i]) begin
                    drop_d[i] = 1'b1;
                end else begin
                    pending_d[i]          = 1'b1;
                    arg_lat_d[8*i +: 8]   = bus.arg[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= 3'b000;
            arg_lat_q  <= 24'h0;
            opnd_q     <= 8'h00;
            src_q      <= 2'd0;
            rr_q       <= 2'd0;
            idx_q      <= 4'd0;
            gap_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            arg_lat_q  <= arg_lat_d;
            opnd_q     <= opnd_d;
            src_q      <= src_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.active_src = (state_q == ST_IDLE) ? 2'd0 : src_q;
    assign bus.done       = done_q;
    assign bus.drop       = drop_q;
endmodule

// File: tb/tb_uart_msg_sched.sv
// Bench for uart_msg_sched: message-level model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_uart_msg_sched;
    localparam int GAP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    uart_msg_sched_if bus();

    uart_msg_sched #(.GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] t1_exp [6] = '{8'h49, 8'h2D, 8'h33, 8'h2D, 8'h23, 8'h00};
    logic [7:0] pick_b [9] = '{8'h50, 8'h49, 8'h43, 8'h4B, 8'h2D, 8'h42, 8'h2D, 8'h23, 8'h00};
    logic [7:0] pick_1 [9] = '{8'h50, 8'h49, 8'h43, 8'h4B, 8'h2D, 8'h31, 8'h2D, 8'h23, 8'h00};
    logic       pat [4]    = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Message-level model: pending flags, a queue of bytes still to send, a gap count.
    logic [2:0] m_pend;
    logic [7:0] m_lat [3];
    int         m_rr, m_gap, m_cur;
    logic [7:0] m_q [$];
    logic [7:0] m_data;
    logic       m_done;
    logic [2:0] m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 3'b000;
            m_rr   = 0;
            m_gap  = 0;
            m_cur  = 0;
            m_q.delete();
            m_data = 8'h00;
            m_done = 1'b0;
            m_drop = 3'b000;
        end else begin
            int    w;
            string pre;
            w      = -1;
            m_done = 1'b0;
            m_drop = 3'b000;
            if (m_q.size() > 0) begin
                if (bus.tx_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_done = 1'b1;
                        m_gap  = GAP;
                    end
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                for (int k = 0; k < 3; k++)
                    if (w < 0 && m_pend[(m_rr + k) % 3]) w = (m_rr + k) % 3;
                if (w >= 0) begin
                    if (w == 0)      pre = "I-";
                    else if (w == 1) pre = "PICK-";
                    else             pre = "DUMP-";
                    for (int j = 0; j < pre.len(); j++) m_q.push_back(pre[j]);
                    m_q.push_back(m_lat[w]);
                    m_q.push_back(8'h2D);
                    m_q.push_back(8'h23);
                    m_q.push_back(8'h00);
                    m_pend[w] = 1'b0;
                    m_rr      = (w + 1) % 3;
                    m_cur     = w;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (bus.req[i]) begin
                    if (m_pend[i]) m_drop[i] = 1'b1;
                    else begin
                        m_pend[i] = 1'b1;
                        m_lat[i]  = bus.arg[8*i +: 8];
                    end
                end
            end
            if (m_q.size() > 0) m_data = m_q[0];
        end
    end

    always @(negedge clk) begin
        logic cv, cb;
        cv = (m_q.size() > 0);
        cb = cv || (m_gap > 0);
        chk("tx_valid",   32'(bus.tx_valid),   32'(cv));
        chk("tx_data",    32'(bus.tx_data),    32'(m_data));
        chk("busy",       32'(bus.busy),       32'(cb));
        chk("active_src", 32'(bus.active_src), cb ? 32'(m_cur) : 32'd0);
        chk("done",       32'(bus.done),       32'(m_done));
        chk("drop",       32'(bus.drop),       32'(m_drop));
    end

    // Observed traffic, for the literal checks below.
    logic [7:0] cap [$];
    int         starts [$];
    int         srcs [$];
    int         done_cnt  = 0;
    int         valid_cnt = 0;
    int         drop_cnt [3] = '{0, 0, 0};
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.tx_valid && !prev_valid) begin
                starts.push_back(cyc);
                srcs.push_back(int'(bus.active_src));
            end
            if (bus.tx_valid) valid_cnt++;
            if (bus.tx_valid && bus.tx_ready) cap.push_back(bus.tx_data);
            if (bus.done) done_cnt++;
            for (int i = 0; i < 3; i++) if (bus.drop[i]) drop_cnt[i]++;
            prev_valid = bus.tx_valid;
        end
    end

    function automatic logic [7:0] capb(input int idx);
        return (idx < cap.size()) ? cap[idx] : 8'hEE;
    endfunction

    function automatic int get_start(input int idx);
        return (idx < starts.size()) ? starts[idx] : -1;
    endfunction

    function automatic int get_src(input int idx);
        return (idx < srcs.size()) ? srcs[idx] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input int budget, input bit bp);
        int k;
        k = 0;
        while (m_q.size() > 0 || m_gap > 0 || m_pend != 3'b000) begin
            if (k >= budget) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wait_quiet: still busy after %0d cycles", k);
                break;
            end
            if (bp) bus.tx_ready = pat[k % 4];
            tick();
            k++;
        end
        bus.tx_ready = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, sb, dc, c, k;
        bus.req      = 3'b000;
        bus.arg      = 24'h0;
        bus.tx_ready = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_tx_valid",   32'(bus.tx_valid),   32'd0);
        chk("rst_tx_data",    32'(bus.tx_data),    32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_active_src", 32'(bus.active_src), 32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_drop",       32'(bus.drop),       32'd0);
        rst_n = 1'b1;
        tick();

        // Single IDENT with operand '3'.
        b = cap.size(); sb = starts.size(); dc = done_cnt; c = cyc;
        bus.arg = 24'h000033;
        bus.req = 3'b001;
        tick();
        bus.req = 3'b000;
        wait_quiet(100, 1'b0);
        chk("t1_len", 32'(cap.size() - b), 32'd6);
        for (int i = 0; i < 6; i++) chk("t1_byte", 32'(capb(b + i)), 32'(t1_exp[i]));
        chk("t1_start", 32'(get_start(sb)), 32'(c + 2));
        chk("t1_done_cnt", 32'(done_cnt - dc), 32'd1);

        // rr now points at PICK: DUMP must win over IDENT.
        b = cap.size(); sb = starts.size();
        bus.arg = 24'h640061;
        bus.req = 3'b101;
        tick();
        bus.req = 3'b000;
        wait_quiet(100, 1'b0);
        chk("rr_first",  32'(get_src(sb)),     32'd2);
        chk("rr_second", 32'(get_src(sb + 1)), 32'd0);
        chk("rr_dump_op",  32'(capb(b + 5)),  32'h64);
        chk("rr_ident_op", 32'(capb(b + 11)), 32'h61);

        // Fresh reset, then all three at once with GAP=4.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        b = cap.size(); sb = starts.size(); c = cyc;
        bus.arg = 24'h434241;
        bus.req = 3'b111;
        tick();
        bus.req = 3'b000;
        wait_quiet(200, 1'b0);
        chk("t2_order0", 32'(get_src(sb)),     32'd0);
        chk("t2_order1", 32'(get_src(sb + 1)), 32'd1);
        chk("t2_order2", 32'(get_src(sb + 2)), 32'd2);
        chk("t2_start0", 32'(get_start(sb)), 32'(c + 2));
        chk("t2_gap01",  32'(get_start(sb + 1) - get_start(sb)),     32'd11);
        chk("t2_gap12",  32'(get_start(sb + 2) - get_start(sb + 1)), 32'd14);
        chk("t2_len",    32'(cap.size() - b), 32'd24);
        for (int i = 0; i < 9; i++) chk("t2_pick", 32'(capb(b + 6 + i)), 32'(pick_b[i]));

        // Duplicate PICK while pending, then backpressure on the whole stream.
        b = cap.size(); sb = starts.size(); dc = drop_cnt[1];
        bus.arg = 24'h000078;
        bus.req = 3'b001;
        tick();
        bus.arg = 24'h003100;
        bus.req = 3'b010;
        tick();
        bus.arg = 24'h003200;
        bus.req = 3'b010;
        tick();
        bus.req = 3'b000;
        wait_quiet(300, 1'b1);
        chk("dup_drop_cnt", 32'(drop_cnt[1] - dc), 32'd1);
        chk("dup_len",      32'(cap.size() - b),  32'd15);
        chk("dup_src1",     32'(get_src(sb + 1)), 32'd1);
        for (int i = 0; i < 9; i++) chk("dup_pick", 32'(capb(b + 6 + i)), 32'(pick_1[i]));

        // Reset after the third DUMP byte with IDENT still pending.
        b = cap.size(); sb = starts.size();
        bus.arg = 24'h7A0069;
        bus.req = 3'b101;
        tick();
        bus.req = 3'b000;
        k = 0;
        while (cap.size() - b < 3 && k < 40) begin
            tick();
            k++;
        end
        chk("mid_reach_3", 32'(cap.size() - b), 32'd3);
        chk("mid_src",     32'(get_src(sb)),    32'd2);
        chk("mid_byte2",   32'(capb(b + 2)),    32'h4D);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(bus.tx_valid), 32'd0);
        chk("mid_async_busy",  32'(bus.busy),     32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        c = valid_cnt;
        sb = starts.size();
        repeat (30) tick();
        chk("post_rst_valid", 32'(valid_cnt - c),     32'd0);
        chk("post_rst_start", 32'(starts.size() - sb), 32'd0);
        chk("post_rst_len",   32'(cap.size() - b),     32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
